// File: rtl/prpg_pattern_analyzer.sv
// Statistics stage for PRPG patterns: Hamming distance between consecutive
// patterns, running HD sum/pair count, sequential-divider average, and seed period.
module prpg_pattern_analyzer #(
    parameter int W     = 8,
    parameter int CNT_W = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    input  logic [W-1:0]             in_pattern,
    output logic                     in_ready,
    input  logic                     finish,
    input  logic                     clear,
    output logic [$clog2(W+1)-1:0]   hd_last,
    output logic [CNT_W-1:0]         hd_sum,
    output logic [CNT_W-1:0]         pair_cnt,
    output logic [CNT_W-1:0]         avg_hd,
    output logic [CNT_W-1:0]         avg_rem,
    output logic [CNT_W-1:0]         period,
    output logic                     period_found,
    output logic                     stat_valid
);

    localparam int HD_W = $clog2(W + 1);
    localparam int DC_W = $clog2(CNT_W);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DIV  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t             state_q, state_d;
    logic [W-1:0]       seed_q, seed_d;
    logic [W-1:0]       prev_q, prev_d;
    logic [HD_W-1:0]    hd_last_q, hd_last_d;
    logic [CNT_W-1:0]   hd_sum_q, hd_sum_d;
    logic [CNT_W-1:0]   pair_cnt_q, pair_cnt_d;
    logic [CNT_W-1:0]   per_cnt_q, per_cnt_d;
    logic [CNT_W-1:0]   period_q, period_d;
    logic               period_found_q, period_found_d;
    logic [CNT_W-1:0]   avg_hd_q, avg_hd_d;
    logic [CNT_W-1:0]   avg_rem_q, avg_rem_d;
    logic [CNT_W-1:0]   quo_q, quo_d;
    logic [CNT_W-1:0]   rem_q, rem_d;
    logic [DC_W-1:0]    div_cnt_q, div_cnt_d;

    logic [W-1:0]       diff_bits;
    logic [HD_W-1:0]    pop;
    logic [CNT_W:0]     div_shift;
    logic [CNT_W:0]     div_diff;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == '1) ? v : v + 1'b1;
    endfunction

    function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] a,
                                                 input logic [HD_W-1:0]  h);
        logic [CNT_W:0] s;
        s = {1'b0, a} + (CNT_W + 1)'(h);
        return s[CNT_W] ? '1 : s[CNT_W-1:0];
    endfunction

    generate
        for (genvar gi = 0; gi < W; gi++) begin : g_xor
            assign diff_bits[gi] = prev_q[gi] ^ in_pattern[gi];
        end
    endgenerate

    always_comb begin
        pop = '0;
        for (int i = 0; i < W; i++) begin
            pop = pop + HD_W'(diff_bits[i]);
        end
    end

    // Restoring step: the remainder is always below the divisor, so the
    // sign bit of the trial subtraction decides the quotient bit.
    assign div_shift = {rem_q, quo_q[CNT_W-1]};
    assign div_diff  = div_shift - {1'b0, pair_cnt_q};

    always_comb begin
        state_d        = state_q;
        seed_d         = seed_q;
        prev_d         = prev_q;
        hd_last_d      = hd_last_q;
        hd_sum_d       = hd_sum_q;
        pair_cnt_d     = pair_cnt_q;
        per_cnt_d      = per_cnt_q;
        period_d       = period_q;
        period_found_d = period_found_q;
        avg_hd_d       = avg_hd_q;
        avg_rem_d      = avg_rem_q;
        quo_d          = quo_q;
        rem_d          = rem_q;
        div_cnt_d      = div_cnt_q;

        if (clear) begin
            state_d        = S_IDLE;
            seed_d         = '0;
            prev_d         = '0;
            hd_last_d      = '0;
            hd_sum_d       = '0;
            pair_cnt_d     = '0;
            per_cnt_d      = '0;
            period_d       = '0;
            period_found_d = 1'b0;
            avg_hd_d       = '0;
            avg_rem_d      = '0;
            quo_d          = '0;
            rem_d          = '0;
            div_cnt_d      = '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (finish) begin
                        state_d = S_DONE;
                    end else if (in_valid) begin
                        seed_d  = in_pattern;
                        prev_d  = in_pattern;
                        state_d = S_RUN;
                    end
                end
                S_RUN: begin
                    if (in_valid) begin
                        hd_last_d  = pop;
                        hd_sum_d   = sat_add(hd_sum_q, pop);
                        pair_cnt_d = sat_inc(pair_cnt_q);
                        prev_d     = in_pattern;
                        per_cnt_d  = sat_inc(per_cnt_q);
                        if ((in_pattern == seed_q) && !period_found_q) begin
                            period_d       = per_cnt_d;
                            period_found_d = 1'b1;
                        end
                    end
                    // A pattern accepted alongside finish is already folded into the dividend.
                    if (finish) begin
                        if (pair_cnt_d == '0) begin
                            state_d = S_DONE;
                        end else begin
                            state_d   = S_DIV;
                            quo_d     = hd_sum_d;
                            rem_d     = '0;
                            div_cnt_d = '0;
                        end
                    end
                end
                S_DIV: begin
                    if (!div_diff[CNT_W]) begin
                        rem_d = div_diff[CNT_W-1:0];
                        quo_d = {quo_q[CNT_W-2:0], 1'b1};
                    end else begin
                        rem_d = div_shift[CNT_W-1:0];
                        quo_d = {quo_q[CNT_W-2:0], 1'b0};
                    end
                    div_cnt_d = div_cnt_q + 1'b1;
                    if (div_cnt_q == DC_W'(CNT_W - 1)) begin
                        state_d   = S_DONE;
                        avg_hd_d  = quo_d;
                        avg_rem_d = rem_d;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= S_IDLE;
            seed_q         <= '0;
            prev_q         <= '0;
            hd_last_q      <= '0;
            hd_sum_q       <= '0;
            pair_cnt_q     <= '0;
            per_cnt_q      <= '0;
            period_q       <= '0;
            period_found_q <= 1'b0;
            avg_hd_q       <= '0;
            avg_rem_q      <= '0;
            quo_q          <= '0;
            rem_q          <= '0;
            div_cnt_q      <= '0;
        end else begin
            state_q        <= state_d;
            seed_q         <= seed_d;
            prev_q         <= prev_d;
            hd_last_q      <= hd_last_d;
            hd_sum_q       <= hd_sum_d;
            pair_cnt_q     <= pair_cnt_d;
            per_cnt_q      <= per_cnt_d;
            period_q       <= period_d;
            period_found_q <= period_found_d;
            avg_hd_q       <= avg_hd_d;
            avg_rem_q      <= avg_rem_d;
            quo_q          <= quo_d;
            rem_q          <= rem_d;
            div_cnt_q      <= div_cnt_d;
        end
    end

    assign in_ready     = (state_q == S_IDLE) || (state_q == S_RUN);
    assign stat_valid   = (state_q == S_DONE);
    assign hd_last      = hd_last_q;
    assign hd_sum       = hd_sum_q;
    assign pair_cnt     = pair_cnt_q;
    assign avg_hd       = avg_hd_q;
    assign avg_rem      = avg_rem_q;
    assign period       = period_q;
    assign period_found = period_found_q;

endmodule

// File: tb/tb_prpg_pattern_analyzer.sv
// Directed bench for prpg_pattern_analyzer: a default-width instance and a
// CNT_W=4 instance share stimulus; expected values are hand-computed.
module tb_prpg_pattern_analyzer;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic [7:0]  in_pattern;
    logic        finish;
    logic        clear;

    logic        a_in_ready, a_period_found, a_stat_valid;
    logic [3:0]  a_hd_last;
    logic [15:0] a_hd_sum, a_pair_cnt, a_avg_hd, a_avg_rem, a_period;

    logic        b_in_ready, b_period_found, b_stat_valid;
    logic [3:0]  b_hd_last;
    logic [3:0]  b_hd_sum, b_pair_cnt, b_avg_hd, b_avg_rem, b_period;

    int tests  = 0;
    int failed = 0;

    always #5 clk = ~clk;

    prpg_pattern_analyzer #(.W(8), .CNT_W(16)) dut_a (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_pattern(in_pattern),
        .in_ready(a_in_ready), .finish(finish), .clear(clear),
        .hd_last(a_hd_last), .hd_sum(a_hd_sum), .pair_cnt(a_pair_cnt),
        .avg_hd(a_avg_hd), .avg_rem(a_avg_rem), .period(a_period),
        .period_found(a_period_found), .stat_valid(a_stat_valid)
    );

    prpg_pattern_analyzer #(.W(8), .CNT_W(4)) dut_b (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_pattern(in_pattern),
        .in_ready(b_in_ready), .finish(finish), .clear(clear),
        .hd_last(b_hd_last), .hd_sum(b_hd_sum), .pair_cnt(b_pair_cnt),
        .avg_hd(b_avg_hd), .avg_rem(b_avg_rem), .period(b_period),
        .period_found(b_period_found), .stat_valid(b_stat_valid)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Advance one clock; outputs are then sampled 1 time unit after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] p);
        in_valid   = 1'b1;
        in_pattern = p;
        step();
        in_valid   = 1'b0;
        $display("[TB] send %02h hd_last=%0d hd_sum=%0d pair_cnt=%0d period=%0d found=%0d",
                 p, a_hd_last, a_hd_sum, a_pair_cnt, a_period, a_period_found);
    endtask

    task automatic pulse_finish();
        finish = 1'b1;
        step();
        finish = 1'b0;
        $display("[TB] finish in_ready=%0d stat_valid=%0d", a_in_ready, a_stat_valid);
    endtask

    task automatic do_clear();
        clear = 1'b1;
        step();
        clear = 1'b0;
        $display("[TB] clear");
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, "_in_ready"},   a_in_ready, 1);
        chk({tag, "_stat_valid"}, a_stat_valid, 0);
        chk({tag, "_hd_last"},    a_hd_last, 0);
        chk({tag, "_hd_sum"},     a_hd_sum, 0);
        chk({tag, "_pair_cnt"},   a_pair_cnt, 0);
        chk({tag, "_avg_hd"},     a_avg_hd, 0);
        chk({tag, "_avg_rem"},    a_avg_rem, 0);
        chk({tag, "_period"},     a_period, 0);
        chk({tag, "_found"},      a_period_found, 0);
        chk({tag, "_b_in_ready"}, b_in_ready, 1);
        chk({tag, "_b_hd_sum"},   b_hd_sum, 0);
    endtask

    initial begin
        rst        = 1'b1;
        in_valid   = 1'b0;
        in_pattern = 8'h00;
        finish     = 1'b0;
        clear      = 1'b0;
        step();
        step();
        rst = 1'b0;
        chk_idle("reset");

        // Basic statistics: 00, FF, 0F, 00
        send(8'h00);
        send(8'hFF);
        chk("basic_hd1", a_hd_last, 8);
        send(8'h0F);
        chk("basic_hd2", a_hd_last, 4);
        send(8'h00);
        chk("basic_hd3", a_hd_last, 4);
        chk("basic_sum", a_hd_sum, 16);
        chk("basic_pairs", a_pair_cnt, 3);
        chk("basic_period", a_period, 3);
        chk("basic_found", a_period_found, 1);
        chk("basic_b_sum_sat", b_hd_sum, 15);
        chk("basic_b_pairs", b_pair_cnt, 3);
        pulse_finish();
        // Backpressure: in_valid held through DIV and DONE
        in_valid   = 1'b1;
        in_pattern = 8'hFF;
        chk("bp_in_ready_div", a_in_ready, 0);
        chk("basic_sv_t1", a_stat_valid, 0);
        repeat (15) step();
        chk("basic_sv_t16", a_stat_valid, 0);
        step();
        chk("basic_sv_t17", a_stat_valid, 1);
        chk("basic_avg", a_avg_hd, 5);
        chk("basic_rem", a_avg_rem, 1);
        chk("bp_pairs_div", a_pair_cnt, 3);
        chk("bp_sum_div", a_hd_sum, 16);
        chk("basic_b_avg", b_avg_hd, 5);
        chk("basic_b_rem", b_avg_rem, 0);
        chk("basic_b_sv", b_stat_valid, 1);
        finish = 1'b1;
        repeat (3) step();
        finish   = 1'b0;
        in_valid = 1'b0;
        chk("bp_in_ready_done", a_in_ready, 0);
        chk("bp_pairs_done", a_pair_cnt, 3);
        chk("bp_avg_done", a_avg_hd, 5);
        chk("bp_sv_done", a_stat_valid, 1);

        do_clear();
        chk_idle("clear");

        // Simultaneous finish and transfer; CNT_W=4 instance saturates
        send(8'h00);
        send(8'hFF);
        in_valid   = 1'b1;
        in_pattern = 8'h00;
        finish     = 1'b1;
        step();
        in_valid = 1'b0;
        finish   = 1'b0;
        chk("sim_pairs", a_pair_cnt, 2);
        chk("sim_sum", a_hd_sum, 16);
        chk("sim_period", a_period, 2);
        chk("sim_found", a_period_found, 1);
        chk("sim_in_ready", a_in_ready, 0);
        chk("sat_b_sum", b_hd_sum, 15);
        chk("sat_b_pairs", b_pair_cnt, 2);
        repeat (3) step();
        chk("sat_b_sv_t4", b_stat_valid, 0);
        step();
        chk("sat_b_sv_t5", b_stat_valid, 1);
        chk("sat_b_avg", b_avg_hd, 7);
        chk("sat_b_rem", b_avg_rem, 1);
        repeat (11) step();
        chk("sim_sv_t16", a_stat_valid, 0);
        step();
        chk("sim_sv_t17", a_stat_valid, 1);
        chk("sim_avg", a_avg_hd, 8);
        chk("sim_rem", a_avg_rem, 0);

        // Single pattern then finish
        do_clear();
        send(8'hA5);
        pulse_finish();
        chk("single_sv", a_stat_valid, 1);
        chk("single_avg", a_avg_hd, 0);
        chk("single_pairs", a_pair_cnt, 0);
        chk("single_found", a_period_found, 0);

        // Later repeats of the seed leave period unchanged
        do_clear();
        send(8'h00);
        send(8'hFF);
        send(8'h00);
        chk("rep_period_first", a_period, 2);
        send(8'hFF);
        send(8'h00);
        send(8'h00);
        chk("rep_period_kept", a_period, 2);
        chk("rep_pairs", a_pair_cnt, 5);
        chk("rep_sum", a_hd_sum, 32);
        chk("rep_hd_last", a_hd_last, 0);

        // Abort division with clear at DIV cycle 5
        do_clear();
        send(8'h01);
        send(8'h03);
        pulse_finish();
        repeat (4) step();
        chk("abort_clr_in_div", a_in_ready, 0);
        do_clear();
        chk_idle("abort_clr");
        step();
        chk("abort_clr_sv_later", a_stat_valid, 0);
        send(8'h00);
        send(8'hFF);
        pulse_finish();
        repeat (16) step();
        chk("fresh1_sv", a_stat_valid, 1);
        chk("fresh1_avg", a_avg_hd, 8);
        chk("fresh1_rem", a_avg_rem, 0);

        // Abort division with rst at DIV cycle 5
        do_clear();
        send(8'h01);
        send(8'h03);
        pulse_finish();
        repeat (4) step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        $display("[TB] rst");
        chk_idle("abort_rst");
        send(8'h00);
        send(8'h07);
        send(8'h00);
        send(8'h01);
        chk("fresh2_sum", a_hd_sum, 7);
        chk("fresh2_pairs", a_pair_cnt, 3);
        chk("fresh2_period", a_period, 2);
        pulse_finish();
        repeat (15) step();
        chk("fresh2_sv_t16", a_stat_valid, 0);
        step();
        chk("fresh2_sv", a_stat_valid, 1);
        chk("fresh2_avg", a_avg_hd, 2);
        chk("fresh2_rem", a_avg_rem, 1);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
